axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
- AXI4 responder that terminates the LSU/IFU master ports onto an on-chip word-addressed SRAM model.
- Single-port, one transaction in flight, read and write share one FSM.
- Supports FIXED and INCR bursts, byte strobes, ID echo, latency injection, and DECERR/SLVERR responses, so the master's handshakes and exception paths are exercised in simulation.

Parameters:
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- DEPTH_LOG2, 10, log2 of the number of 32-bit words.
- RD_LAT, 1, cycles from AR accept to first rvalid (1..15).
- WR_LAT, 1, cycles from last W beat to bvalid (1..15).

Ports:
- i_clock  in  1  clock, all logic on rising edge.
- i_reset  in  1  synchronous active-low reset.
- i_axi_araddr/arvalid/arid/arlen/arsize/arburst  in  32/1/4/8/3/2  read address channel.
- o_axi_arready  out  1.
- o_axi_rdata/rresp/rvalid/rlast/rid  out  32/2/1/1/4  read data channel.
- i_axi_rready  in  1.
- i_axi_awaddr/awvalid/awid/awlen/awsize/awburst  in  32/1/4/8/3/2  write address channel.
- o_axi_awready  out  1.
- i_axi_wdata/wstrb/wvalid/wlast  in  32/4/1/1  write data channel.
- o_axi_wready  out  1.
- o_axi_bresp/bvalid/bid  out  2/1/4  write response channel.
- i_axi_bready  in  1.

Behaviour:
- Reset (i_reset==0 at posedge):
  - FSM to IDLE, latency counter and beat counter to 0.
  - All ready/valid outputs 0; rdata, rresp, rid, bresp, bid, rlast all 0.
  - SRAM contents are not reset.
  - Reset mid-transaction abandons the transaction with no response.
- FSM states: IDLE, RD_LAT, RD_DATA, WR_DATA, WR_LAT, WR_RESP.
- IDLE, write path (has priority):
  - If awvalid && wvalid, assert o_axi_awready and o_axi_wready combinationally in the same cycle. The master deasserts only on joint acceptance, so these must coincide.
  - Latch id, addr, len, size, burst; perform the first beat's write.
  - Go to WR_LAT if awlen==0, else WR_DATA.
- IDLE, read path: else if arvalid, assert o_axi_arready, latch the AR fields, load the latency counter, go to RD_LAT.
- Ready signals are never asserted outside IDLE (awready/arready) or outside IDLE/WR_DATA (wready).
- RD_LAT: count RD_LAT-1 further cycles, then assert rvalid with beat 0 (so the first rvalid occurs RD_LAT cycles after the AR handshake). Then go to RD_DATA.
- RD_DATA:
  - Hold rdata/rresp/rlast/rid stable while rvalid && !rready.
  - On handshake: if the beat was last, drop rvalid and go to IDLE; else present the next beat in the next cycle (zero bubble).
  - rlast=1 exactly on beat arlen.
- WR_DATA:
  - wready=1; each wvalid&&wready writes one beat.
  - On wlast, or when the beat count reaches awlen, go to WR_LAT.
  - A wlast/beat-count mismatch sets the error flag; the resulting bresp is SLVERR.
- WR_LAT: count WR_LAT cycles, then assert bvalid with bid = latched id and bresp = accumulated response; go to WR_RESP.
- WR_RESP: hold until bready, then go to IDLE.
- Addressing:
  - Word index = (addr - BASE_ADDR) >> 2.
  - rdata is always the full aligned word; the master performs lane selection.
  - Writes apply wstrb per byte lane; wdata is already lane-aligned.
- Bursts:
  - FIXED (00): address constant.
  - INCR (01): address += (1<<size) per beat.
  - WRAP (10) and reserved (11): SLVERR.
- Errors (response encodings):
  - Address outside [BASE_ADDR, BASE_ADDR + 4*2^DEPTH_LOG2): DECERR 2'b11, rdata 0, no write.
  - size > 2, or a WRAP/reserved burst: SLVERR 2'b10, rdata 0, no write.
  - Otherwise OKAY 2'b00.
- Error scope:
  - Read errors are evaluated per beat.
  - Write bresp is the worst of all beats (DECERR > SLVERR > OKAY); the beats that were OK are still written.
- Simultaneous awvalid&&wvalid and arvalid in IDLE: the write wins; arvalid stays pending and is served after WR_RESP completes.
- awvalid without wvalid in IDLE: not accepted, and it does not block a pending read.

Test Plan:
- Write then read: AW/W addr 0x8000_0004, data 0xDEADBEEF, strb 4'hF, id 3 → awready and wready high in the same cycle; bvalid after WR_LAT cycles with bresp 00, bid 3. AR at the same address, RD_LAT=1 → rvalid 1 cycle after arready; rdata 0xDEADBEEF, rlast 1, rid matches AR id.
- Byte strobe: write 0x0000AB00 with strb 4'b0010 to 0x8000_0004 over 0xDEADBEEF → read returns 0xDEADABEF.
- INCR read burst: arlen 3, arsize 2, from 0x8000_0000 preloaded with 1,2,3,4 → four beats 1,2,3,4, rlast only on beat 4. Holding rready low for 2 cycles on beat 2 keeps rdata=2 stable.
- Error responses:
  - Read at 0x0000_1000 → rresp 11, rdata 0.
  - Write with awsize 3 → bresp 10, memory unchanged.
  - WRAP read → rresp 10.
- Arbitration: awvalid&&wvalid and arvalid asserted in the same cycle → write handshake first; arready is asserted only after the bready handshake; the read returns the new data.
- Reset mid-burst: i_reset low during beat 2 of a 4-beat read → next cycle rvalid 0, FSM IDLE; a fresh AR after release completes normally.

Source files
------------

// File: rtl/axi_sram_slave.sv
// AXI4 responder backed by a word-addressed on-chip SRAM model.
// It handles one transaction at a time and uses a single FSM for both reads and writes.
// It supports FIXED/INCR bursts, byte strobes, ID echo, configurable
// response latency and DECERR/SLVERR generation.
module axi_sram_slave #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          DEPTH_LOG2 = 10,
  parameter int          RD_LAT     = 1,
  parameter int          WR_LAT     = 1
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [31:0] i_axi_araddr,
  input  logic        i_axi_arvalid,
  input  logic [3:0]  i_axi_arid,
  input  logic [7:0]  i_axi_arlen,
  input  logic [2:0]  i_axi_arsize,
  input  logic [1:0]  i_axi_arburst,
  output logic        o_axi_arready,
  output logic [31:0] o_axi_rdata,
  output logic [1:0]  o_axi_rresp,
  output logic        o_axi_rvalid,
  output logic        o_axi_rlast,
  output logic [3:0]  o_axi_rid,
  input  logic        i_axi_rready,
  input  logic [31:0] i_axi_awaddr,
  input  logic        i_axi_awvalid,
  input  logic [3:0]  i_axi_awid,
  input  logic [7:0]  i_axi_awlen,
  input  logic [2:0]  i_axi_awsize,
  input  logic [1:0]  i_axi_awburst,
  output logic        o_axi_awready,
  input  logic [31:0] i_axi_wdata,
  input  logic [3:0]  i_axi_wstrb,
  input  logic        i_axi_wvalid,
  input  logic        i_axi_wlast,
  output logic        o_axi_wready,
  output logic [1:0]  o_axi_bresp,
  output logic        o_axi_bvalid,
  output logic [3:0]  o_axi_bid,
  input  logic        i_axi_bready
);

  localparam int          WORDS       = 1 << DEPTH_LOG2;
  localparam logic [32:0] SPAN        = 33'd4 << DEPTH_LOG2;
  // Latency 1 skips the latency state entirely, so the counter preload is LAT-2.
  localparam logic [3:0]  RD_CNT0     = (RD_LAT > 1) ? 4'(RD_LAT - 2) : 4'd0;
  localparam logic [3:0]  WR_CNT0     = (WR_LAT > 1) ? 4'(WR_LAT - 2) : 4'd0;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_LAT, S_RD_DATA, S_WR_DATA, S_WR_LAT, S_WR_RESP
  } state_t;

  state_t      state, next_state;
  logic [31:0] mem [WORDS];
  logic [31:0] addr;
  logic [3:0]  id;
  logic [7:0]  len;
  logic [2:0]  size;
  logic [1:0]  burst;
  logic [3:0]  lat_cnt;
  logic [7:0]  beat_cnt;
  logic [7:0]  beat_nxt;
  logic [1:0]  werr;

  logic        ld_rbeat, rd_last;
  logic [31:0] rd_addr;
  logic [2:0]  rd_size;
  logic [1:0]  rd_burst, rd_resp;
  logic [3:0]  rd_id;
  logic        wr_beat, wr_done, wr_proto_err, mem_we;
  logic [31:0] wr_addr;
  logic [2:0]  wr_size;
  logic [1:0]  wr_burst, wr_resp, wr_final;
  logic [3:0]  wr_id;

  // DECERR outranks SLVERR: an out-of-window beat is the worse fault.
  function automatic logic [1:0] beat_resp(input logic [31:0] a, input logic [2:0] sz,
                                           input logic [1:0] bu);
    logic [31:0] off;
    off = a - BASE_ADDR;
    if ({1'b0, off} >= SPAN) return RESP_DECERR;
    if (sz > 3'd2 || bu[1]) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] sz,
                                            input logic [1:0] bu);
    if (bu == 2'b01) return a + (32'd1 << sz);
    return a;
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [31:0] a);
    return DEPTH_LOG2'((a - BASE_ADDR) >> 2);
  endfunction

  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign beat_nxt = beat_cnt + 8'd1;

  // State register.
  always_ff @(posedge i_clock) begin
    if (!i_reset) state <= S_IDLE;
    else          state <= next_state;
  end

  // Next state, handshake readies and per-beat address/response selection.
  always_comb begin
    next_state    = state;
    o_axi_arready = 1'b0;
    o_axi_awready = 1'b0;
    o_axi_wready  = 1'b0;
    ld_rbeat      = 1'b0;
    rd_addr       = addr;
    rd_size       = size;
    rd_burst      = burst;
    rd_id         = id;
    rd_last       = (len == 8'd0);
    wr_beat       = 1'b0;
    wr_addr       = addr;
    wr_size       = size;
    wr_burst      = burst;
    wr_id         = id;
    wr_done       = 1'b0;
    wr_proto_err  = 1'b0;
    case (state)
      S_IDLE: begin
        // AW and W are taken together only, and a write beats a pending read.
        if (i_axi_awvalid && i_axi_wvalid) begin
          o_axi_awready = 1'b1;
          o_axi_wready  = 1'b1;
          wr_beat       = 1'b1;
          wr_addr       = i_axi_awaddr;
          wr_size       = i_axi_awsize;
          wr_burst      = i_axi_awburst;
          wr_id         = i_axi_awid;
          wr_done       = i_axi_wlast || (i_axi_awlen == 8'd0);
          wr_proto_err  = i_axi_wlast != (i_axi_awlen == 8'd0);
          if (!wr_done)          next_state = S_WR_DATA;
          else if (WR_LAT == 1)  next_state = S_WR_RESP;
          else                   next_state = S_WR_LAT;
        end else if (i_axi_arvalid) begin
          o_axi_arready = 1'b1;
          if (RD_LAT == 1) begin
            ld_rbeat   = 1'b1;
            rd_addr    = i_axi_araddr;
            rd_size    = i_axi_arsize;
            rd_burst   = i_axi_arburst;
            rd_id      = i_axi_arid;
            rd_last    = (i_axi_arlen == 8'd0);
            next_state = S_RD_DATA;
          end else begin
            next_state = S_RD_LAT;
          end
        end
      end
      S_RD_LAT: begin
        if (lat_cnt == 4'd0) begin
          ld_rbeat   = 1'b1;
          next_state = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (i_axi_rready) begin
          if (o_axi_rlast) begin
            next_state = S_IDLE;
          end else begin
            ld_rbeat = 1'b1;
            rd_addr  = next_addr(addr, size, burst);
            rd_last  = (beat_nxt == len);
          end
        end
      end
      S_WR_DATA: begin
        o_axi_wready = 1'b1;
        if (i_axi_wvalid) begin
          wr_beat      = 1'b1;
          wr_addr      = next_addr(addr, size, burst);
          wr_done      = i_axi_wlast || (beat_nxt == len);
          wr_proto_err = i_axi_wlast != (beat_nxt == len);
          if (wr_done) next_state = (WR_LAT == 1) ? S_WR_RESP : S_WR_LAT;
        end
      end
      S_WR_LAT: begin
        if (lat_cnt == 4'd0) next_state = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (i_axi_bready) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
    rd_resp  = beat_resp(rd_addr, rd_size, rd_burst);
    wr_resp  = beat_resp(wr_addr, wr_size, wr_burst);
    wr_final = worst((state == S_IDLE) ? RESP_OKAY : werr,
                     worst(wr_resp, wr_proto_err ? RESP_SLVERR : RESP_OKAY));
    mem_we   = i_reset && wr_beat && (wr_resp == RESP_OKAY);
  end

  // Transaction context, latency/beat counters and the registered R and B channels.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      lat_cnt      <= 4'd0;
      beat_cnt     <= 8'd0;
      o_axi_rvalid <= 1'b0;
      o_axi_rdata  <= 32'd0;
      o_axi_rresp  <= 2'b00;
      o_axi_rlast  <= 1'b0;
      o_axi_rid    <= 4'd0;
      o_axi_bvalid <= 1'b0;
      o_axi_bresp  <= 2'b00;
      o_axi_bid    <= 4'd0;
    end else begin
      if ((state == S_RD_LAT || state == S_WR_LAT) && lat_cnt != 4'd0)
        lat_cnt <= lat_cnt - 4'd1;
      if (o_axi_arready) begin
        addr     <= i_axi_araddr;
        id       <= i_axi_arid;
        len      <= i_axi_arlen;
        size     <= i_axi_arsize;
        burst    <= i_axi_arburst;
        beat_cnt <= 8'd0;
        lat_cnt  <= RD_CNT0;
      end
      if (o_axi_awready) begin
        id       <= i_axi_awid;
        len      <= i_axi_awlen;
        size     <= i_axi_awsize;
        burst    <= i_axi_awburst;
        beat_cnt <= 8'd0;
      end
      if (ld_rbeat) begin
        o_axi_rvalid <= 1'b1;
        o_axi_rresp  <= rd_resp;
        o_axi_rdata  <= (rd_resp == RESP_OKAY) ? mem[word_idx(rd_addr)] : 32'd0;
        o_axi_rid    <= rd_id;
        o_axi_rlast  <= rd_last;
        addr         <= rd_addr;
        if (state == S_RD_DATA) beat_cnt <= beat_nxt;
      end else if (state == S_RD_DATA && i_axi_rready) begin
        o_axi_rvalid <= 1'b0;
      end
      if (wr_beat) begin
        werr <= wr_final;
        addr <= wr_addr;
        if (state == S_WR_DATA) beat_cnt <= beat_nxt;
        if (wr_done) begin
          if (WR_LAT == 1) begin
            o_axi_bvalid <= 1'b1;
            o_axi_bresp  <= wr_final;
            o_axi_bid    <= wr_id;
          end else begin
            lat_cnt <= WR_CNT0;
          end
        end
      end
      if (state == S_WR_LAT && lat_cnt == 4'd0) begin
        o_axi_bvalid <= 1'b1;
        o_axi_bresp  <= werr;
        o_axi_bid    <= id;
      end
      if (state == S_WR_RESP && i_axi_bready) o_axi_bvalid <= 1'b0;
    end
  end

  // SRAM array: byte-lane writes for OKAY beats only, never reset.
  always_ff @(posedge i_clock) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_axi_wstrb[b]) mem[word_idx(wr_addr)][8*b +: 8] <= i_axi_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: directed steps followed by randomized
// transactions, all compared against a word-array reference model.
module tb_axi_sram_slave;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int RDL = 1;
  localparam int WRL = 2;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic [3:0]  arid = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rlast;
  logic [3:0]  rid;
  logic        rready = 1'b0;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic [3:0]  awid = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wlast = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic [3:0]  bid;
  logic        bready = 1'b0;

  always #5 i_clock = ~i_clock;

  axi_sram_slave #(.BASE_ADDR(BASE), .DEPTH_LOG2(10), .RD_LAT(RDL), .WR_LAT(WRL)) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_axi_araddr(araddr), .i_axi_arvalid(arvalid), .i_axi_arid(arid),
    .i_axi_arlen(arlen), .i_axi_arsize(arsize), .i_axi_arburst(arburst),
    .o_axi_arready(arready),
    .o_axi_rdata(rdata), .o_axi_rresp(rresp), .o_axi_rvalid(rvalid),
    .o_axi_rlast(rlast), .o_axi_rid(rid), .i_axi_rready(rready),
    .i_axi_awaddr(awaddr), .i_axi_awvalid(awvalid), .i_axi_awid(awid),
    .i_axi_awlen(awlen), .i_axi_awsize(awsize), .i_axi_awburst(awburst),
    .o_axi_awready(awready),
    .i_axi_wdata(wdata), .i_axi_wstrb(wstrb), .i_axi_wvalid(wvalid),
    .i_axi_wlast(wlast), .o_axi_wready(wready),
    .o_axi_bresp(bresp), .o_axi_bvalid(bvalid), .o_axi_bid(bid),
    .i_axi_bready(bready)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  logic [31:0] refm [1024];
  logic [31:0] wq [$];
  logic [3:0]  sq [$];
  logic [31:0] last_rdata;
  logic [1:0]  last_resp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge i_clock);
    #1;
  endtask

  // Reference model: beat k address, per-beat response, and memory updates.
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [2:0] sz,
                                            input logic [1:0] bu, input int k);
    if (bu == 2'b01) return a + 32'(k * (1 << sz));
    return a;
  endfunction

  function automatic logic [1:0] model_resp(input logic [31:0] a, input logic [2:0] sz,
                                            input logic [1:0] bu);
    longint unsigned la, lb;
    la = a;
    lb = BASE;
    if (la < lb || la >= lb + 4096) return 2'b11;
    if (sz > 3'd2 || bu >= 2'd2) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             output logic [1:0] resp);
    logic [31:0] a, off;
    logic [1:0]  r;
    resp = 2'b00;
    for (int k = 0; k <= int'(len); k++) begin
      a = beat_addr(addr, size, burst, k);
      r = model_resp(a, size, burst);
      if (r > resp) resp = r;
      if (r == 2'b00) begin
        off = a - BASE;
        for (int b = 0; b < 4; b++)
          if (sq[k][b]) refm[off[11:2]][8*b +: 8] = wq[k][8*b +: 8];
      end
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int bstall);
    logic [1:0] exp_resp;
    int n;
    model_write(addr, len, size, burst, exp_resp);
    awaddr = addr; awid = id; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    wdata = wq[0]; wstrb = sq[0]; wlast = (len == 8'd0); wvalid = 1'b1;
    #1;
    chk("aw_ready", awready, 1'b1);
    chk("aw_w_same_cycle", wready, awready);
    nxt();
    awvalid = 1'b0;
    for (int k = 1; k <= int'(len); k++) begin
      wdata = wq[k]; wstrb = sq[k]; wlast = (k == int'(len));
      #1;
      chk($sformatf("w_ready[%0d]", k), wready, 1'b1);
      nxt();
    end
    wvalid = 1'b0; wlast = 1'b0;
    n = 1;
    while (!bvalid && n < 40) begin
      nxt();
      n++;
    end
    chk("b_latency", n, WRL);
    chk("b_resp", bresp, exp_resp);
    chk("b_id", bid, id);
    for (int s = 0; s < bstall; s++) begin
      nxt();
      chk("b_hold", {bvalid, bid, bresp}, {1'b1, id, exp_resp});
    end
    bready = 1'b1;
    nxt();
    bready = 1'b0;
    chk("b_drop", bvalid, 1'b0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input int stall_k, input int stall_n);
    logic [31:0] a, off, ed;
    logic [1:0]  r;
    int n;
    araddr = addr; arid = id; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    #1;
    chk("ar_ready", arready, 1'b1);
    nxt();
    arvalid = 1'b0;
    n = 1;
    while (!rvalid && n < 40) begin
      nxt();
      n++;
    end
    chk("r_latency", n, RDL);
    for (int k = 0; k <= int'(len); k++) begin
      a   = beat_addr(addr, size, burst, k);
      r   = model_resp(a, size, burst);
      off = a - BASE;
      ed  = (r == 2'b00) ? refm[off[11:2]] : 32'd0;
      chk($sformatf("r_valid[%0d]", k), rvalid, 1'b1);
      chk($sformatf("r_data[%0d]", k), rdata, ed);
      chk($sformatf("r_resp[%0d]", k), rresp, r);
      chk($sformatf("r_id[%0d]", k), rid, id);
      chk($sformatf("r_last[%0d]", k), rlast, (k == int'(len)));
      last_rdata = rdata;
      last_resp  = rresp;
      if (k == stall_k) begin
        for (int s = 0; s < stall_n; s++) begin
          nxt();
          chk("r_hold", {rvalid, rlast, rresp, rdata}, {1'b1, (k == int'(len)), r, ed});
        end
      end
      rready = 1'b1;
      nxt();
      rready = 1'b0;
    end
    chk("r_drop", rvalid, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state.
    repeat (3) nxt();
    chk("rst_ready", {arready, awready, wready}, 3'b000);
    chk("rst_valid", {rvalid, bvalid, rlast}, 3'b000);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ids_resps", {rid, rresp, bid, bresp}, 12'd0);
    i_reset = 1'b1;
    nxt();

    // Preload the working windows so every later read has a known value.
    for (int w = 0; w < 32; w++) begin
      wq = {$urandom()}; sq = {4'hF};
      do_write(BASE + 32'(4 * w), 4'(w), 8'd0, 3'd2, 2'b01, 0);
    end
    for (int w = 1020; w < 1024; w++) begin
      wq = {$urandom()}; sq = {4'hF};
      do_write(BASE + 32'(4 * w), 4'd1, 8'd0, 3'd2, 2'b01, 0);
    end

    // Write then read back.
    wq = {32'hDEADBEEF}; sq = {4'hF};
    do_write(BASE + 32'd4, 4'd3, 8'd0, 3'd2, 2'b01, 1);
    do_read(BASE + 32'd4, 4'd5, 8'd0, 3'd2, 2'b01, 0, 0);
    chk("wr_rd_literal", last_rdata, 32'hDEADBEEF);

    // Single byte lane write.
    wq = {32'h0000AB00}; sq = {4'b0010};
    do_write(BASE + 32'd4, 4'd4, 8'd0, 3'd2, 2'b01, 0);
    do_read(BASE + 32'd4, 4'd6, 8'd0, 3'd2, 2'b01, 0, 0);
    chk("strobe_literal", last_rdata, 32'hDEADABEF);

    // INCR write burst preload, then INCR read burst with a 2-cycle stall on beat 2.
    wq = {32'd1, 32'd2, 32'd3, 32'd4}; sq = {4'hF, 4'hF, 4'hF, 4'hF};
    do_write(BASE, 4'd8, 8'd3, 3'd2, 2'b01, 2);
    do_read(BASE, 4'd9, 8'd3, 3'd2, 2'b01, 1, 2);
    chk("incr_last_literal", last_rdata, 32'd4);

    // Error responses.
    do_read(32'h0000_1000, 4'd1, 8'd0, 3'd2, 2'b01, 0, 0);
    chk("decerr_resp", last_resp, 2'b11);
    chk("decerr_data", last_rdata, 32'd0);
    wq = {32'hFFFF_FFFF}; sq = {4'hF};
    do_write(BASE + 32'd8, 4'd2, 8'd0, 3'd3, 2'b01, 0);
    do_read(BASE + 32'd8, 4'd2, 8'd0, 3'd2, 2'b01, 0, 0);
    chk("slverr_mem_kept", last_rdata, 32'd3);
    do_read(BASE, 4'd7, 8'd3, 3'd2, 2'b10, 0, 0);
    chk("wrap_resp", last_resp, 2'b10);

    // Write and read requested together: write wins, read waits for the B handshake.
    wq = {32'h1234_5678}; sq = {4'hF};
    begin
      logic [1:0] er;
      int n;
      model_write(BASE + 32'd20, 8'd0, 3'd2, 2'b01, er);
      awaddr = BASE + 32'd20; awid = 4'd2; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01;
      awvalid = 1'b1; wvalid = 1'b1; wdata = wq[0]; wstrb = 4'hF; wlast = 1'b1;
      araddr = BASE + 32'd20; arid = 4'd6; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01;
      arvalid = 1'b1;
      #1;
      chk("arb_aw_w_ready", {awready, wready}, 2'b11);
      chk("arb_ar_blocked", arready, 1'b0);
      nxt();
      awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
      n = 0;
      while (!bvalid && n < 40) begin
        chk("arb_ar_wait", arready, 1'b0);
        nxt();
        n++;
      end
      chk("arb_bvalid", {bvalid, bresp, bid}, {1'b1, er, 4'd2});
      chk("arb_ar_during_b", arready, 1'b0);
      bready = 1'b1;
      nxt();
      bready = 1'b0;
      chk("arb_ar_after_b", arready, 1'b1);
      nxt();
      arvalid = 1'b0;
      chk("arb_r", {rvalid, rlast, rid, rresp}, {1'b1, 1'b1, 4'd6, 2'b00});
      chk("arb_r_data", rdata, 32'h1234_5678);
      rready = 1'b1;
      nxt();
      rready = 1'b0;
    end

    // AW without W neither gets accepted nor blocks a read.
    awaddr = BASE + 32'd24; awvalid = 1'b1; wvalid = 1'b0;
    #1;
    chk("aw_only_no_accept", awready, 1'b0);
    do_read(BASE + 32'd12, 4'd10, 8'd0, 3'd2, 2'b01, 0, 0);
    chk("aw_only_still_no_accept", awready, 1'b0);
    awvalid = 1'b0;

    // Reset during beat 2 of a 4-beat read.
    araddr = BASE; arid = 4'd7; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    #1;
    chk("rstb_ar_ready", arready, 1'b1);
    nxt();
    arvalid = 1'b0;
    chk("rstb_beat1", {rvalid, rdata}, {1'b1, refm[0]});
    rready = 1'b1;
    nxt();
    rready = 1'b0;
    chk("rstb_beat2", {rvalid, rdata}, {1'b1, refm[1]});
    i_reset = 1'b0;
    nxt();
    chk("rstb_rvalid_low", {rvalid, rlast}, 2'b00);
    chk("rstb_rdata_zero", rdata, 32'd0);
    i_reset = 1'b1;
    nxt();
    chk("rstb_no_resume", rvalid, 1'b0);
    do_read(BASE + 32'd8, 4'd11, 8'd1, 3'd2, 2'b01, 0, 0);

    // Randomized transactions against the reference model.
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      logic [2:0]  sz;
      logic [1:0]  bu;
      logic [7:0]  ln;
      int          mode;
      mode = int'($urandom_range(0, 9));
      sz = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 3)) : 3'd2;
      bu = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      ln = 8'($urandom_range(0, 3));
      if (mode < 7)
        a = BASE + 32'(4 * $urandom_range(0, 15)) + ((sz < 3'd2) ? 32'($urandom_range(0, 3)) : 32'd0);
      else if (mode < 9)
        a = BASE + 32'h0FF8 + 32'(4 * $urandom_range(0, 1));
      else
        a = ($urandom_range(0, 1) != 0) ? 32'h0000_1000 : BASE - 32'd4;
      if ($urandom_range(0, 1) != 0) begin
        wq.delete();
        sq.delete();
        for (int k = 0; k <= int'(ln); k++) begin
          wq.push_back($urandom());
          sq.push_back(4'($urandom_range(0, 15)));
        end
        do_write(a, 4'($urandom_range(0, 15)), ln, sz, bu, int'($urandom_range(0, 2)));
      end else begin
        do_read(a, 4'($urandom_range(0, 15)), ln, sz, bu,
                int'($urandom_range(0, int'(ln))), int'($urandom_range(0, 2)));
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
